// File: rtl/link_bringup_seq.sv
// Link bring-up sequencer: QPLL reset and lock, MMCM reset and lock, then an all-links-valid hold.
// Define LINK_SEQ_AUTOSTART_EN to launch the sequence on the first clock after reset release.
module link_bringup_seq #(
  parameter int unsigned N_LINKS      = 2,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 125000,
  parameter int unsigned VALID_HOLD   = 256,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic               sysClk125,
  input  logic               sysClk125RstN,
  input  logic               start,
  input  logic               qpll_lock,
  input  logic               qpll_refclklost,
  input  logic               clk_link_lock,
  input  logic [N_LINKS-1:0] link_valid,
  output logic               qpll_reset,
  output logic               mmcm_reset,
  output logic [N_LINKS-1:0] link_up,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         err_code,
  output logic [1:0]         retry_cnt,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StQpllRst  = 3'd1,
    StQpllWait = 3'd2,
    StMmcmRst  = 3'd3,
    StMmcmWait = 3'd4,
    StLinkWait = 3'd5,
    StUp       = 3'd6,
    StFail     = 3'd7
  } state_e;

  localparam logic [31:0] RstLast     = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TimeoutLast = 32'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] HoldTarget  = 16'(VALID_HOLD);
  localparam logic [1:0]  MaxRetry    = 2'(MAX_RETRY);

  localparam int unsigned SyncW = N_LINKS + 3;

  // Two-flop synchronizers; packed as {link_valid, clk_link_lock, qpll_refclklost, qpll_lock}.
  logic [SyncW-1:0] meta_q, sync_q;

  always_ff @(posedge sysClk125 or negedge sysClk125RstN) begin
    if (!sysClk125RstN) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {link_valid, clk_link_lock, qpll_refclklost, qpll_lock};
      sync_q <= meta_q;
    end
  end

  logic               qpll_lock_s;
  logic               qpll_refclklost_s;
  logic               clk_link_lock_s;
  logic [N_LINKS-1:0] link_valid_s;

  assign qpll_lock_s       = sync_q[0];
  assign qpll_refclklost_s = sync_q[1];
  assign clk_link_lock_s   = sync_q[2];
  assign link_valid_s      = sync_q[SyncW-1:3];

  logic auto_start;

`ifdef LINK_SEQ_AUTOSTART_EN
  // One-cycle pulse in the first clock period after reset release.
  logic boot_arm_q, boot_fired_q;

  always_ff @(posedge sysClk125 or negedge sysClk125RstN) begin
    if (!sysClk125RstN) begin
      boot_arm_q   <= 1'b0;
      boot_fired_q <= 1'b0;
    end else begin
      boot_arm_q   <= 1'b1;
      boot_fired_q <= boot_arm_q;
    end
  end

  assign auto_start = boot_arm_q & ~boot_fired_q;
`else
  assign auto_start = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [15:0]        hold_q, hold_d;
  logic [1:0]         retry_q, retry_d;
  logic [2:0]         err_q, err_d;
  logic               qpll_reset_q, qpll_reset_d;
  logic               mmcm_reset_q, mmcm_reset_d;
  logic [N_LINKS-1:0] link_up_q, link_up_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic       go;
  logic       enter;
  logic       timeout;
  logic [2:0] timeout_code;
  logic       all_valid;

  assign all_valid = &link_valid_s;
  assign go        = start | (auto_start & (state_q == StIdle));

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    err_d        = err_q;
    enter        = 1'b0;
    timeout      = 1'b0;
    timeout_code = 3'd0;

    if (go) begin
      // A start request wins over any timeout or lock loss in the same cycle.
      state_d = StQpllRst;
      retry_d = '0;
      err_d   = '0;
      enter   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StQpllRst: begin
          if (cnt_q >= RstLast) state_d = StQpllWait;
        end
        StQpllWait: begin
          if (qpll_lock_s && !qpll_refclklost_s) begin
            state_d = StMmcmRst;
          end else if (cnt_q >= TimeoutLast) begin
            timeout      = 1'b1;
            timeout_code = 3'd1;
          end
        end
        StMmcmRst: begin
          if (cnt_q >= RstLast) state_d = StMmcmWait;
        end
        StMmcmWait: begin
          if (clk_link_lock_s) begin
            state_d = StLinkWait;
          end else if (cnt_q >= TimeoutLast) begin
            timeout      = 1'b1;
            timeout_code = 3'd2;
          end
        end
        StLinkWait: begin
          if (hold_q >= HoldTarget) begin
            state_d = StUp;
          end else if (cnt_q >= TimeoutLast) begin
            timeout      = 1'b1;
            timeout_code = 3'd3;
          end
        end
        StUp: begin
          if (!qpll_lock_s || qpll_refclklost_s || !clk_link_lock_s) begin
            state_d = StQpllRst;
            err_d   = 3'd4;
            retry_d = '0;
          end
        end
        StFail: begin
        end
        default: state_d = StIdle;
      endcase

      if (timeout) begin
        err_d = timeout_code;
        if (retry_q < MaxRetry) begin
          retry_d = retry_q + 2'd1;
          state_d = StQpllRst;
        end else begin
          state_d = StFail;
        end
      end

      enter = (state_d != state_q);
    end
  end

  always_comb begin
    cnt_d  = enter ? '0 : cnt_q + 32'd1;
    // Counts consecutive all-valid cycles; any zero bit or leaving LINK_WAIT clears it.
    hold_d = ((state_q == StLinkWait) && all_valid && !enter) ? hold_q + 16'd1 : '0;

    qpll_reset_d = (state_d == StQpllRst);
    mmcm_reset_d = (state_d == StMmcmRst);
    busy_d       = (state_d != StIdle) && (state_d != StUp) && (state_d != StFail);
    done_d       = (state_d == StUp);
    error_d      = (state_d == StFail);
    link_up_d    = (state_d == StUp) ? link_valid_s : '0;
  end

  always_ff @(posedge sysClk125 or negedge sysClk125RstN) begin
    if (!sysClk125RstN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hold_q       <= '0;
      retry_q      <= '0;
      err_q        <= '0;
      qpll_reset_q <= 1'b0;
      mmcm_reset_q <= 1'b0;
      link_up_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      retry_q      <= retry_d;
      err_q        <= err_d;
      qpll_reset_q <= qpll_reset_d;
      mmcm_reset_q <= mmcm_reset_d;
      link_up_q    <= link_up_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign qpll_reset = qpll_reset_q;
  assign mmcm_reset = mmcm_reset_q;
  assign link_up    = link_up_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule
